hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Pipeline hazard controller sitting beside the Decode stage of the 5-stage processor. Tracks in-flight register writes per architectural register, and generates the `DepStall`/`FetchStall` qualifiers that Decode forwards down the pipe to Execute, Memory and Writeback. Holds fetch across unresolved branches/jumps. Sequences the execute datapath so it only ever sees hazard-free instructions or explicit bubbles.

## Interface
- No parameters; register file fixed at 16 entries (4-bit index), pending counters 2 bits.
- I_CLOCK  in  1  pipeline clock; all state updates on negedge
- I_RESET_N  in  1  synchronous active-low reset, sampled on negedge I_CLOCK
- I_LOCK  in  1  pipeline running; when 0, no issue, no state change except reset
- I_IssueValid  in  1  Decode holds an instruction this cycle
- I_Src1Idx, I_Src2Idx  in  4 each  source register indices
- I_Src1Used, I_Src2Used  in  1 each  source actually read
- I_DestIdx  in  4  destination register index
- I_WritesReg  in  1  instruction writes I_DestIdx (ALU ops, MOV/MOVI, LDW, JSR/JSRR)
- I_IsBranch  in  1  BRx/JMP/JSR/JSRR (PC-changing)
- I_WBValid  in  1  Writeback commits a register this cycle
- I_WBDestIdx  in  4  register being committed
- I_BranchResolve  in  1  branch/jump target resolved, PC redirected
- O_DepStall  out  1  combinational; Decode must insert a bubble
- O_FetchStall  out  1  combinational; Fetch must hold PC, Decode inserts bubble
- O_Issue  out  1  combinational; instruction accepted this cycle
- O_Busy  out  16  registered; bit r = pending counter of r nonzero
- O_Underflow  out  1  registered sticky error flag

## Operation
- State per register r: cnt[r], 2-bit count of issued-but-uncommitted writes.
- FSM states: RUN, BR_WAIT, REDIRECT.
  - RUN: normal issue. On O_Issue with I_IsBranch=1 -> BR_WAIT.
  - BR_WAIT: O_FetchStall=1; no issue. On I_BranchResolve=1 -> REDIRECT.
  - REDIRECT: O_FetchStall=1 for exactly one cycle (redirected PC enters Fetch) -> RUN.
  - I_BranchResolve in RUN or REDIRECT ignored.
- Hazard (RAW): src k used and cnt[Srck]!=0. WAW saturation: I_WritesReg and cnt[DestIdx]==3.
- O_DepStall = I_LOCK & I_IssueValid & state==RUN & (RAW | saturation).
- O_FetchStall = I_LOCK & state!=RUN.
- O_Issue = I_LOCK & I_IssueValid & state==RUN & ~O_DepStall.
- Counter update per negedge when I_LOCK=1: +1 on O_Issue&I_WritesReg for DestIdx; -1 on I_WBValid for WBDestIdx; both on same register -> unchanged.
- WB to register with cnt==0 and no same-cycle issue: counter stays 0, O_Underflow set (sticky until reset).
- I_WBValid processed even when I_IssueValid=0 or state!=RUN.
- Branch writing a register (JSR/JSRR) increments its dest counter as any writer.

## Timing
- Reset (I_RESET_N=0 at negedge): all cnt=0, state=RUN, O_Busy=0, O_Underflow=0; takes priority over all inputs, including mid-BR_WAIT.
- While I_RESET_N=0 combinational outputs reflect reset-state registers (O_FetchStall=0).
- Stall/issue decision same cycle as inputs; counter effects visible next cycle.
- Issue of a branch: O_FetchStall rises the cycle after issue; minimum fetch bubble = 2 cycles (BR_WAIT + REDIRECT) when resolve arrives in the first BR_WAIT cycle.
- I_LOCK=0: state, counters and O_Underflow frozen; WB ignored.

## Configuration
- SCOREBOARD_BYPASS_EN defined: a source with cnt==1 whose register is committed by I_WBValid in the same cycle is not a hazard (WB value forwarded by register file write-through); instruction issues that cycle.
- Undefined: same case stalls; instruction issues the following cycle once cnt==0.
- Saturation and branch behaviour identical in both builds.

## Test plan
- Reset: hold I_RESET_N=0 two cycles during BR_WAIT with cnt[3]=2 -> state RUN, O_Busy=0x0000, O_FetchStall=0, O_Underflow=0.
- RAW: issue ADD dest r2; next cycle issue src1=r2 -> O_DepStall=1, O_Issue=0 until WB r2; O_Busy bit2 clears cycle after WB.
- Bypass: cnt[5]=1, issue src1=r5 with I_WBValid, I_WBDestIdx=5 same cycle -> O_Issue=1 with SCOREBOARD_BYPASS_EN, O_DepStall=1 without.
- Saturation: three back-to-back MOVI r7 with no WB -> cnt[7]=3, fourth MOVI r7 -> O_DepStall=1; one WB r7 -> issues next cycle.
- Branch: issue BRZ, resolve 3 cycles later -> O_FetchStall=1 for 4 cycles (3 BR_WAIT + 1 REDIRECT), then 0; JSR r7 also sets O_Busy bit7.
- Underflow/simultaneous: WB r4 with cnt[4]=0 -> O_Underflow=1 sticky; issue dest r1 with WB r1, cnt[1]=1 -> cnt[1] stays 1.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Decode-side RAW/WAW scoreboard and branch fetch-hold controller.
//
// Ports:
//   I_CLOCK          pipeline clock; all state updates on the falling edge
//   I_RESET_N        synchronous active-low reset, sampled on the falling edge
//   I_LOCK           pipeline running; when low nothing issues and state is frozen
//   I_IssueValid     Decode holds an instruction
//   I_Src1Idx/Used   first source register and whether it is read
//   I_Src2Idx/Used   second source register and whether it is read
//   I_DestIdx        destination register
//   I_WritesReg      instruction writes I_DestIdx
//   I_IsBranch       instruction changes the PC
//   I_WBValid        Writeback commits I_WBDestIdx this cycle
//   I_WBDestIdx      register being committed
//   I_BranchResolve  branch target resolved, PC redirected
//   O_DepStall       Decode must insert a bubble (data hazard)
//   O_FetchStall     Fetch holds PC while a branch is unresolved or redirecting
//   O_Issue          instruction accepted this cycle
//   O_Busy           bit r set while register r has pending writes
//   O_Underflow      sticky: a commit arrived for a register with no pending write
//
// Build option: define SCOREBOARD_BYPASS_EN to let a source whose only pending
// write is committed in the same cycle issue immediately (register file
// write-through forwards the value).
module hazard_scoreboard (
    input  logic        I_CLOCK,
    input  logic        I_RESET_N,
    input  logic        I_LOCK,
    input  logic        I_IssueValid,
    input  logic [3:0]  I_Src1Idx,
    input  logic [3:0]  I_Src2Idx,
    input  logic        I_Src1Used,
    input  logic        I_Src2Used,
    input  logic [3:0]  I_DestIdx,
    input  logic        I_WritesReg,
    input  logic        I_IsBranch,
    input  logic        I_WBValid,
    input  logic [3:0]  I_WBDestIdx,
    input  logic        I_BranchResolve,
    output logic        O_DepStall,
    output logic        O_FetchStall,
    output logic        O_Issue,
    output logic [15:0] O_Busy,
    output logic        O_Underflow
);
    typedef enum logic [1:0] {RUN, BR_WAIT, REDIRECT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt [16];
    logic [1:0]  cnt_nxt [16];
    logic [15:0] inc, dec;
    logic        fwd1, fwd2, raw, sat, uf;

`ifdef SCOREBOARD_BYPASS_EN
    assign fwd1 = I_WBValid && I_WBDestIdx == I_Src1Idx && cnt[I_Src1Idx] == 2'd1;
    assign fwd2 = I_WBValid && I_WBDestIdx == I_Src2Idx && cnt[I_Src2Idx] == 2'd1;
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign raw = (I_Src1Used && cnt[I_Src1Idx] != 2'd0 && !fwd1) ||
                 (I_Src2Used && cnt[I_Src2Idx] != 2'd0 && !fwd2);
    assign sat = I_WritesReg && cnt[I_DestIdx] == 2'd3;

    assign O_DepStall   = I_LOCK && I_IssueValid && state == RUN && (raw || sat);
    assign O_FetchStall = I_LOCK && state != RUN;
    assign O_Issue      = I_LOCK && I_IssueValid && state == RUN && !O_DepStall;

    assign inc = (O_Issue && I_WritesReg) ? 16'd1 << I_DestIdx : 16'd0;
    assign dec = I_WBValid ? 16'd1 << I_WBDestIdx : 16'd0;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      state_nxt = (O_Issue && I_IsBranch) ? BR_WAIT : RUN;
            BR_WAIT:  state_nxt = I_BranchResolve ? REDIRECT : BR_WAIT;
            default:  state_nxt = RUN;
        endcase
    end

    // Simultaneous issue and commit on one register cancel out; a lone commit
    // on an idle register leaves it at zero and raises the error flag.
    always_comb begin
        uf = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cnt_nxt[i] = cnt[i];
            O_Busy[i]  = cnt[i] != 2'd0;
            if (inc[i] && !dec[i])
                cnt_nxt[i] = cnt[i] + 2'd1;
            else if (dec[i] && !inc[i]) begin
                if (cnt[i] == 2'd0)
                    uf = 1'b1;
                else
                    cnt_nxt[i] = cnt[i] - 2'd1;
            end
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (!I_RESET_N) begin
            state       <= RUN;
            O_Underflow <= 1'b0;
            for (int i = 0; i < 16; i++)
                cnt[i] <= 2'd0;
        end else if (I_LOCK) begin
            state       <= state_nxt;
            O_Underflow <= O_Underflow || uf;
            for (int i = 0; i < 16; i++)
                cnt[i] <= cnt_nxt[i];
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed self-checking bench for hazard_scoreboard.
// Inputs change just after each falling edge; outputs are sampled 1ns later,
// well away from the falling edge where state updates.
module tb_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n, lock, iv, s1u, s2u, wr, br, wbv, res;
    logic [3:0]  s1, s2, dst, wbd;
    logic        dep, fst, iss, uf;
    logic [15:0] busy;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(lock), .I_IssueValid(iv),
        .I_Src1Idx(s1), .I_Src2Idx(s2), .I_Src1Used(s1u), .I_Src2Used(s2u),
        .I_DestIdx(dst), .I_WritesReg(wr), .I_IsBranch(br), .I_WBValid(wbv),
        .I_WBDestIdx(wbd), .I_BranchResolve(res), .O_DepStall(dep),
        .O_FetchStall(fst), .O_Issue(iss), .O_Busy(busy), .O_Underflow(uf)
    );

    task automatic clr();
        rst_n = 1'b1; lock = 1'b1; iv = 1'b0; s1u = 1'b0; s2u = 1'b0;
        wr = 1'b0; br = 1'b0; wbv = 1'b0; res = 1'b0;
        s1 = 4'd0; s2 = 4'd0; dst = 4'd0; wbd = 4'd0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr(); iv = 1'b1; wr = 1'b1; dst = 4'd3;
        #1; n_cmp++; if (iss !== 1'b1) begin n_bad++; $display("FAIL rst_setup_issue got %b exp 1", iss); end
        tick();
        br = 1'b1;
        tick();
        clr();
        #1; n_cmp++; if (fst !== 1'b1 || busy !== 16'h0008) begin n_bad++; $display("FAIL rst_setup_brwait fst %b busy %h exp 1 0008", fst, busy); end
        wbv = 1'b1; wbd = 4'd9;
        tick();
        wbv = 1'b0;
        #1; n_cmp++; if (uf !== 1'b1) begin n_bad++; $display("FAIL rst_setup_uf got %b exp 1", uf); end
        rst_n = 1'b0;
        tick();
        tick();
        #1; n_cmp++; if (busy !== 16'h0000 || fst !== 1'b0 || uf !== 1'b0) begin n_bad++; $display("FAIL reset_state busy %h fst %b uf %b exp 0000 0 0", busy, fst, uf); end
        rst_n = 1'b1; iv = 1'b1; s1u = 1'b1; s1 = 4'd3;
        #1; n_cmp++; if (iss !== 1'b1 || dep !== 1'b0) begin n_bad++; $display("FAIL reset_run iss %b dep %b exp 1 0", iss, dep); end
        clr();
        tick();
    endtask

    task automatic test_raw();
        clr(); iv = 1'b1; wr = 1'b1; dst = 4'd2; s1u = 1'b1; s2u = 1'b1; s1 = 4'd0; s2 = 4'd1;
        #1; n_cmp++; if (iss !== 1'b1) begin n_bad++; $display("FAIL raw_first_issue got %b exp 1", iss); end
        tick();
        clr();
        #1; n_cmp++; if (busy !== 16'h0004) begin n_bad++; $display("FAIL raw_busy got %h exp 0004", busy); end
        iv = 1'b1; s1u = 1'b1; s1 = 4'd2; wr = 1'b1; dst = 4'd6;
        for (int i = 0; i < 2; i++) begin
            #1; n_cmp++; if (dep !== 1'b1 || iss !== 1'b0) begin n_bad++; $display("FAIL raw_stall%0d dep %b iss %b exp 1 0", i, dep, iss); end
            tick();
        end
        iv = 1'b0; wbv = 1'b1; wbd = 4'd2;
        tick();
        wbv = 1'b0;
        #1; n_cmp++; if (busy !== 16'h0000) begin n_bad++; $display("FAIL raw_wb_clear got %h exp 0000", busy); end
        iv = 1'b1;
        #1; n_cmp++; if (iss !== 1'b1 || dep !== 1'b0) begin n_bad++; $display("FAIL raw_release iss %b dep %b exp 1 0", iss, dep); end
        tick();
        clr(); wbv = 1'b1; wbd = 4'd6;
        #1; n_cmp++; if (busy !== 16'h0040) begin n_bad++; $display("FAIL raw_dest6 got %h exp 0040", busy); end
        tick();
        clr();
    endtask

    task automatic test_bypass();
        clr(); iv = 1'b1; wr = 1'b1; dst = 4'd5;
        tick();
        clr(); iv = 1'b1; s2u = 1'b1; s2 = 4'd5; wbv = 1'b1; wbd = 4'd5;
`ifdef SCOREBOARD_BYPASS_EN
        #1; n_cmp++; if (iss !== 1'b1 || dep !== 1'b0) begin n_bad++; $display("FAIL bypass_same_cycle iss %b dep %b exp 1 0", iss, dep); end
`else
        #1; n_cmp++; if (iss !== 1'b0 || dep !== 1'b1) begin n_bad++; $display("FAIL bypass_same_cycle iss %b dep %b exp 0 1", iss, dep); end
`endif
        tick();
        wbv = 1'b0;
        #1; n_cmp++; if (iss !== 1'b1 || busy !== 16'h0000) begin n_bad++; $display("FAIL bypass_after iss %b busy %h exp 1 0000", iss, busy); end
        clr();
        tick();
    endtask

    task automatic test_saturation();
        clr(); iv = 1'b1; wr = 1'b1; dst = 4'd7;
        for (int i = 0; i < 3; i++) begin
            #1; n_cmp++; if (iss !== 1'b1) begin n_bad++; $display("FAIL sat_fill%0d iss %b exp 1", i, iss); end
            tick();
        end
        #1; n_cmp++; if (dep !== 1'b1 || iss !== 1'b0 || busy !== 16'h0080) begin n_bad++; $display("FAIL sat_stall dep %b iss %b busy %h exp 1 0 0080", dep, iss, busy); end
        wbv = 1'b1; wbd = 4'd7;
        #1; n_cmp++; if (dep !== 1'b1) begin n_bad++; $display("FAIL sat_wb_cycle dep %b exp 1", dep); end
        tick();
        wbv = 1'b0;
        #1; n_cmp++; if (iss !== 1'b1 || dep !== 1'b0) begin n_bad++; $display("FAIL sat_release iss %b dep %b exp 1 0", iss, dep); end
        tick();
        clr(); wbv = 1'b1; wbd = 4'd7;
        tick(); tick(); tick();
        clr();
        #1; n_cmp++; if (busy !== 16'h0000 || uf !== 1'b0) begin n_bad++; $display("FAIL sat_drain busy %h uf %b exp 0000 0", busy, uf); end
    endtask

    task automatic test_branch();
        int stalls;
        clr(); iv = 1'b1; br = 1'b1;
        #1; n_cmp++; if (iss !== 1'b1 || fst !== 1'b0) begin n_bad++; $display("FAIL br_issue iss %b fst %b exp 1 0", iss, fst); end
        tick();
        clr(); iv = 1'b1;
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            res = (i == 2 || i == 3);
            #1;
            if (fst) stalls++;
            if (i < 3) begin
                n_cmp++; if (iss !== 1'b0) begin n_bad++; $display("FAIL br_noissue%0d iss %b exp 0", i, iss); end
            end
            tick();
        end
        n_cmp++; if (stalls !== 4) begin n_bad++; $display("FAIL br_stall_len got %0d exp 4", stalls); end
        clr(); iv = 1'b1; br = 1'b1; wr = 1'b1; dst = 4'd7;
        tick();
        clr();
        #1; n_cmp++; if (busy !== 16'h0080 || fst !== 1'b1) begin n_bad++; $display("FAIL jsr_busy busy %h fst %b exp 0080 1", busy, fst); end
        res = 1'b1;
        tick();
        res = 1'b0; wbv = 1'b1; wbd = 4'd7;
        tick();
        clr(); res = 1'b1;
        #1; n_cmp++; if (busy !== 16'h0000 || fst !== 1'b0) begin n_bad++; $display("FAIL jsr_done busy %h fst %b exp 0000 0", busy, fst); end
        tick();
        #1; n_cmp++; if (fst !== 1'b0) begin n_bad++; $display("FAIL br_resolve_in_run fst %b exp 0", fst); end
        clr();
    endtask

    task automatic test_underflow();
        clr(); wbv = 1'b1; wbd = 4'd4;
        tick();
        clr();
        #1; n_cmp++; if (uf !== 1'b1 || busy !== 16'h0000) begin n_bad++; $display("FAIL uf_set uf %b busy %h exp 1 0000", uf, busy); end
        iv = 1'b1; wr = 1'b1; dst = 4'd1;
        tick();
        #1; n_cmp++; if (uf !== 1'b1 || busy !== 16'h0002) begin n_bad++; $display("FAIL uf_sticky uf %b busy %h exp 1 0002", uf, busy); end
        wbv = 1'b1; wbd = 4'd1;
        #1; n_cmp++; if (iss !== 1'b1) begin n_bad++; $display("FAIL simul_issue iss %b exp 1", iss); end
        tick();
        clr();
        #1; n_cmp++; if (busy !== 16'h0002) begin n_bad++; $display("FAIL simul_hold busy %h exp 0002", busy); end
        wbv = 1'b1; wbd = 4'd1;
        tick();
        clr();
        #1; n_cmp++; if (busy !== 16'h0000) begin n_bad++; $display("FAIL simul_drain busy %h exp 0000", busy); end
    endtask

    task automatic test_lock();
        clr(); iv = 1'b1; wr = 1'b1; dst = 4'd8;
        tick();
        clr(); lock = 1'b0; iv = 1'b1; wr = 1'b1; dst = 4'd9; wbv = 1'b1; wbd = 4'd8;
        #1; n_cmp++; if (iss !== 1'b0 || dep !== 1'b0 || fst !== 1'b0) begin n_bad++; $display("FAIL lock_outs iss %b dep %b fst %b exp 0 0 0", iss, dep, fst); end
        tick();
        #1; n_cmp++; if (busy !== 16'h0100) begin n_bad++; $display("FAIL lock_frozen busy %h exp 0100", busy); end
        lock = 1'b1; iv = 1'b0;
        tick();
        clr();
        #1; n_cmp++; if (busy !== 16'h0000) begin n_bad++; $display("FAIL lock_resume busy %h exp 0000", busy); end
    endtask

    initial begin
        clr(); rst_n = 1'b0;
        tick(); tick();
        test_reset();
        test_raw();
        test_bypass();
        test_saturation();
        test_branch();
        test_underflow();
        test_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
